// File: rtl/video_timing_generator.sv
// Raster timing generator for the VGA output path.
// Counts pixels/lines on a pixel-clock enable and produces registered sync,
// blanking, active-area coordinates and line/frame start strobes.
// Optional feature: define VIDEO_TIMING_PIXEL_INDEX_EN to add the pixel_o
// linear active-pixel index output.
module video_timing_generator #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 400,
    parameter int unsigned V_FRONT   = 12,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 35,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b1,
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
    localparam int unsigned PW = (H_ACTIVE * V_ACTIVE > 1) ? $clog2(H_ACTIVE * V_ACTIVE) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          pix_en_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          video_en_o,
    output logic          hblank_o,
    output logic          vblank_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          line_start_o,
`ifdef VIDEO_TIMING_PIXEL_INDEX_EN
    output logic [PW-1:0] pixel_o,
`endif
    output logic          frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    // Boundary constants sized to the counters; back porch >= 1 keeps them in range.
    localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActEnd = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncLo = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HSyncHi = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VLast   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActEnd = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncLo = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VSyncHi = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          video_en_q, video_en_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Next raster position and the output decode of that position.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_i) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end

        hblank_d      = (h_d >= HActEnd);
        vblank_d      = (v_d >= VActEnd);
        video_en_d    = !hblank_d && !vblank_d;
        hsync_d       = ((h_d >= HSyncLo) && (h_d < HSyncHi)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = ((v_d >= VSyncLo) && (v_d < VSyncHi)) ? VSYNC_POL : ~VSYNC_POL;
        x_d           = video_en_d ? XW'(h_d) : '0;
        y_d           = video_en_d ? YW'(v_d) : '0;
        // Strobes only fire on an advancing cycle, so they last one clk.
        line_start_d  = pix_en_i && (h_d == '0);
        frame_start_d = pix_en_i && (h_d == '0) && (v_d == '0);
    end

    // Counters and registered outputs; levels only move on enabled cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_q           <= HLast;
            v_q           <= VLast;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            video_en_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (pix_en_i) begin
                hsync_q    <= hsync_d;
                vsync_q    <= vsync_d;
                hblank_q   <= hblank_d;
                vblank_q   <= vblank_d;
                video_en_q <= video_en_d;
                x_q        <= x_d;
                y_q        <= y_d;
            end
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign hblank_o      = hblank_q;
    assign vblank_o      = vblank_q;
    assign video_en_o    = video_en_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef VIDEO_TIMING_PIXEL_INDEX_EN
    logic [PW-1:0] pix_cnt_q;
    logic [PW-1:0] pixel_q;

    // Running count of active pixels; restarts at the first pixel of a frame.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pix_cnt_q <= '0;
            pixel_q   <= '0;
        end else if (pix_en_i) begin
            if (frame_start_d) begin
                pixel_q   <= '0;
                pix_cnt_q <= PW'(1);
            end else if (video_en_d) begin
                pixel_q   <= pix_cnt_q;
                pix_cnt_q <= pix_cnt_q + PW'(1);
            end else begin
                pixel_q   <= '0;
            end
        end
    end

    assign pixel_o = pixel_q;
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator with an 8x6 raster
// (H = 4/1/2/1, V = 3/1/1/1, hsync active-low, vsync active-high).
module tb_video_timing_generator;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       pix_en_i = 1'b0;
    logic       hsync_o, vsync_o, video_en_o, hblank_o, vblank_o;
    logic [1:0] x_o, y_o;
    logic       line_start_o, frame_start_o;
`ifdef VIDEO_TIMING_PIXEL_INDEX_EN
    logic [3:0] pixel_o;
`endif

    int checks = 0;
    int errors = 0;
    int mh = 7;  // model position, starts at the reset position
    int mv = 5;

    always #5 clk_i = ~clk_i;

    video_timing_generator #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .pix_en_i     (pix_en_i),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .video_en_o   (video_en_o),
        .hblank_o     (hblank_o),
        .vblank_o     (vblank_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .line_start_o (line_start_o),
`ifdef VIDEO_TIMING_PIXEL_INDEX_EN
        .pixel_o      (pixel_o),
`endif
        .frame_start_o(frame_start_o)
    );

    // Advance the bench's own raster model by one pixel.
    task automatic model_step();
        if (mh == 7) begin
            mh = 0;
            mv = (mv == 5) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic test_reset();
        reset_i  = 1'b1;
        pix_en_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({hsync_o, vsync_o, video_en_o, hblank_o, vblank_o} !== 5'b10011) begin
            errors++;
            $display("FAIL reset_levels got hs/vs/ve/hb/vb=%b expected 10011",
                     {hsync_o, vsync_o, video_en_o, hblank_o, vblank_o});
        end
        checks++;
        if ({x_o, y_o, line_start_o, frame_start_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_xy_strobes got x=%0d y=%0d ls=%b fs=%b expected all 0",
                     x_o, y_o, line_start_o, frame_start_o);
        end
        // Release with the enable low: everything must hold.
        reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({hsync_o, vsync_o, video_en_o, hblank_o, vblank_o, line_start_o, frame_start_o}
            !== 7'b1001100) begin
            errors++;
            $display("FAIL hold_no_enable got %b expected 1001100",
                     {hsync_o, vsync_o, video_en_o, hblank_o, vblank_o,
                      line_start_o, frame_start_o});
        end
    endtask

    task automatic test_raster();
        int fs_first = -1;
        int fs_second = -1;
        int ls_count = 0;
        int ex_hs, ex_vs, ex_hb, ex_vb, ex_ve, ex_x, ex_y, ex_ls, ex_fs;
        for (int c = 0; c < 96; c++) begin
            pix_en_i = 1'b1;
            @(posedge clk_i);
            #1;
            model_step();
            ex_hs = (mh == 5 || mh == 6) ? 0 : 1;
            ex_vs = (mv == 4) ? 1 : 0;
            ex_hb = (mh >= 4) ? 1 : 0;
            ex_vb = (mv >= 3) ? 1 : 0;
            ex_ve = (ex_hb == 0 && ex_vb == 0) ? 1 : 0;
            ex_x  = ex_ve ? mh : 0;
            ex_y  = ex_ve ? mv : 0;
            ex_ls = (mh == 0) ? 1 : 0;
            ex_fs = (mh == 0 && mv == 0) ? 1 : 0;
            checks++;
            if (int'(hsync_o) !== ex_hs || int'(vsync_o) !== ex_vs) begin
                errors++;
                $display("FAIL sync at (%0d,%0d) got hs=%b vs=%b expected hs=%0d vs=%0d",
                         mh, mv, hsync_o, vsync_o, ex_hs, ex_vs);
            end
            checks++;
            if (int'(hblank_o) !== ex_hb || int'(vblank_o) !== ex_vb ||
                int'(video_en_o) !== ex_ve) begin
                errors++;
                $display("FAIL blank at (%0d,%0d) got hb=%b vb=%b ve=%b expected %0d %0d %0d",
                         mh, mv, hblank_o, vblank_o, video_en_o, ex_hb, ex_vb, ex_ve);
            end
            checks++;
            if (int'(x_o) !== ex_x || int'(y_o) !== ex_y) begin
                errors++;
                $display("FAIL xy at (%0d,%0d) got x=%0d y=%0d expected x=%0d y=%0d",
                         mh, mv, x_o, y_o, ex_x, ex_y);
            end
            checks++;
            if (int'(line_start_o) !== ex_ls || int'(frame_start_o) !== ex_fs) begin
                errors++;
                $display("FAIL strobes at (%0d,%0d) got ls=%b fs=%b expected ls=%0d fs=%0d",
                         mh, mv, line_start_o, frame_start_o, ex_ls, ex_fs);
            end
            if (line_start_o === 1'b1) ls_count++;
            if (frame_start_o === 1'b1) begin
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
        end
        checks++;
        if (fs_first !== 0 || fs_second !== 48) begin
            errors++;
            $display("FAIL frame_period got first=%0d second=%0d expected 0 and 48",
                     fs_first, fs_second);
        end
        checks++;
        if (ls_count !== 12) begin
            errors++;
            $display("FAIL line_start_count got %0d expected 12", ls_count);
        end
    endtask

    task automatic test_duty();
        int fs_count = 0;
        int fs_first = -1;
        int fs_last = -1;
        int ex_x, ex_hs, ex_fs;
        logic pen;
        for (int c = 0; c < 150; c++) begin
            pen = (c % 3 == 0);
            pix_en_i = pen;
            @(posedge clk_i);
            #1;
            if (pen) model_step();
            ex_x  = (mh < 4 && mv < 3) ? mh : 0;
            ex_hs = (mh == 5 || mh == 6) ? 0 : 1;
            ex_fs = (pen && mh == 0 && mv == 0) ? 1 : 0;
            checks++;
            if (int'(x_o) !== ex_x || int'(hsync_o) !== ex_hs ||
                int'(frame_start_o) !== ex_fs) begin
                errors++;
                $display("FAIL duty c=%0d at (%0d,%0d) got x=%0d hs=%b fs=%b expected %0d %0d %0d",
                         c, mh, mv, x_o, hsync_o, frame_start_o, ex_x, ex_hs, ex_fs);
            end
            if (frame_start_o === 1'b1) begin
                fs_count++;
                if (fs_first < 0) fs_first = c;
                fs_last = c;
            end
        end
        pix_en_i = 1'b0;
        checks++;
        if (fs_count !== 2 || fs_last - fs_first !== 144) begin
            errors++;
            $display("FAIL duty_frame_period got count=%0d gap=%0d expected 2 and 144",
                     fs_count, fs_last - fs_first);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (!(mh == 5 && mv == 1) && guard < 100) begin
            pix_en_i = 1'b1;
            @(posedge clk_i);
            #1;
            model_step();
            guard++;
        end
        pix_en_i = 1'b0;
        checks++;
        if (guard >= 100 || hsync_o !== 1'b0 || hblank_o !== 1'b1) begin
            errors++;
            $display("FAIL reach_5_1 got guard=%0d hs=%b hb=%b expected <100 0 1",
                     guard, hsync_o, hblank_o);
        end
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;  // still well before the next rising edge
        checks++;
        if ({hsync_o, vsync_o, video_en_o, hblank_o, vblank_o, line_start_o, frame_start_o}
            !== 7'b1001100 || x_o !== 2'd0 || y_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got %b x=%0d y=%0d expected 1001100 x=0 y=0",
                     {hsync_o, vsync_o, video_en_o, hblank_o, vblank_o,
                      line_start_o, frame_start_o}, x_o, y_o);
        end
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        mh = 7;
        mv = 5;
        pix_en_i = 1'b1;
        @(posedge clk_i);
        #1;
        model_step();
        pix_en_i = 1'b0;
        checks++;
        if (frame_start_o !== 1'b1 || line_start_o !== 1'b1 || video_en_o !== 1'b1 ||
            x_o !== 2'd0 || y_o !== 2'd0) begin
            errors++;
            $display("FAIL restart got fs=%b ls=%b ve=%b x=%0d y=%0d expected 1 1 1 0 0",
                     frame_start_o, line_start_o, video_en_o, x_o, y_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (frame_start_o !== 1'b0 || line_start_o !== 1'b0 || video_en_o !== 1'b1) begin
            errors++;
            $display("FAIL strobe_one_clk got fs=%b ls=%b ve=%b expected 0 0 1",
                     frame_start_o, line_start_o, video_en_o);
        end
    endtask

`ifdef VIDEO_TIMING_PIXEL_INDEX_EN
    task automatic test_pixel_index();
        int ex_p;
        // Model sits at (0,0); walk a full frame plus a little.
        for (int c = 0; c < 50; c++) begin
            pix_en_i = 1'b1;
            @(posedge clk_i);
            #1;
            model_step();
            ex_p = (mh < 4 && mv < 3) ? mv * 4 + mh : 0;
            checks++;
            if (int'(pixel_o) !== ex_p) begin
                errors++;
                $display("FAIL pixel_index at (%0d,%0d) got %0d expected %0d",
                         mh, mv, pixel_o, ex_p);
            end
        end
        pix_en_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_raster();
        test_duty();
        test_async_reset();
`ifdef VIDEO_TIMING_PIXEL_INDEX_EN
        test_pixel_index();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Parametrised VGA/video raster timing generator. It replaces the fixed 640x400 sync generator and its internal clock divider with an external pixel-clock enable, configurable porch, sync width and polarity, registered outputs, and line/frame start strobes. It sits between the system clock domain and the frame-buffer read path and the VGA pins of the falling-sand display pipeline.

## Interface
- H_ACTIVE, 640, visible columns
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 400, visible rows
- V_FRONT, 12, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 35, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_o
- VSYNC_POL, 1, asserted level of vsync_o
- Derived: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. All parameters ≥ 1.

Ports:
- clk_i  in  1  system clock (single clock domain)
- reset_i  in  1  asynchronous, active-high reset
- pix_en_i  in  1  pixel-clock enable; the raster advances one pixel per cycle in which it is high
- hsync_o  out  1  horizontal sync at HSYNC_POL when asserted
- vsync_o  out  1  vertical sync at VSYNC_POL when asserted
- video_en_o  out  1  current pixel is in the active area
- hblank_o  out  1  h_count ≥ H_ACTIVE
- vblank_o  out  1  v_count ≥ V_ACTIVE
- x_o  out  $clog2(H_ACTIVE)  active column, 0 outside the active area
- y_o  out  $clog2(V_ACTIVE)  active row, 0 outside the active area
- line_start_o  out  1  one-clk strobe: the raster has just entered h=0
- frame_start_o  out  1  one-clk strobe: the raster has just entered (0,0)
- pixel_o  out  $clog2(H_ACTIVE*V_ACTIVE)  linear active-pixel index. Present only with VIDEO_TIMING_PIXEL_INDEX_EN.

## Operation
- Internal counters: h_count in 0..H_TOTAL-1 and v_count in 0..V_TOTAL-1.
- On each pix_en_i cycle, h_count increments. When h_count = H_TOTAL-1 it wraps to 0 and v_count increments. When v_count = V_TOTAL-1 at the same time, v_count wraps to 0.
- When pix_en_i is low, counters and all level outputs hold.
- Reset places the counters at (H_TOTAL-1, V_TOTAL-1), the last back-porch pixel. The first enabled cycle therefore yields (0,0) together with frame_start_o.
- hsync is asserted when H_ACTIVE+H_FRONT ≤ h_count < H_ACTIVE+H_FRONT+H_SYNC.
- vsync is asserted when V_ACTIVE+V_FRONT ≤ v_count < V_ACTIVE+V_FRONT+V_SYNC. vsync changes only at line wrap.
- video_en_o = !hblank_o && !vblank_o.
- x_o = h_count and y_o = v_count inside the active area; both are 0 otherwise.
- Outputs are decoded from the next counter values and registered. No output carries combinational logic from counters.
- Reset values: hsync_o = ~HSYNC_POL, vsync_o = ~VSYNC_POL, video_en_o = 0, hblank_o = 1, vblank_o = 1, x_o = 0, y_o = 0, line_start_o = 0, frame_start_o = 0, pixel_o = 0.
- Reset asserted mid-frame forces these values immediately, with no clock edge required, and restarts the frame as described above.

## Timing
- Output registers update on the same clk_i edge as the counters. There is zero latency between counter position and outputs, and all outputs are mutually aligned.
- Level outputs stay constant for the whole pixel period, i.e. until the next pix_en_i cycle.
- line_start_o and frame_start_o are high for exactly one clk_i cycle: the cycle after the advancing edge, regardless of the pix_en_i duty cycle. frame_start_o always coincides with line_start_o.
- pix_en_i tied high: frame period = H_TOTAL*V_TOTAL clk_i cycles.
- For 640x400 at 25 MHz, drive pix_en_i as a 1-in-4 strobe from a 100 MHz clk_i.

## Configuration
- VIDEO_TIMING_PIXEL_INDEX_EN defined:
  - pixel_o exists.
  - An incrementer counts active pixels and clears at frame start; no multiplier is used.
  - pixel_o = y_o*H_ACTIVE + x_o while video_en_o is high, and 0 otherwise.
- Undefined: the pixel_o port and its counter are absent.

## Test plan
All scenarios use H = 4/1/2/1 (H_TOTAL = 8) and V = 3/1/1/1 (V_TOTAL = 6).
- Release reset, pix_en_i = 1 -> first cycle shows frame_start_o = 1, line_start_o = 1, x_o = 0, y_o = 0, video_en_o = 1. frame_start_o repeats every 48 clk; line_start_o repeats every 8 clk.
- HSYNC_POL = 0 -> hsync_o = 0 only at h = 5,6 of every line. video_en_o = 1 only at h = 0..3 while v = 0..2. hblank_o = 1 at h = 4..7.
- VSYNC_POL = 1 -> vsync_o = 1 for all 8 pixels of line v = 4 and 0 elsewhere. vblank_o = 1 for v = 3..5.
- pix_en_i high 1 cycle in 3 -> each position holds 3 clk. frame_start_o is high exactly 1 clk. Frame period = 144 clk.
- With VIDEO_TIMING_PIXEL_INDEX_EN -> pixel_o = 11 at (3,2), pixel_o = 0 at (0,0) and in all blanking. It wraps to 0 at the next frame.
- Assert reset_i asynchronously at (5,1) -> outputs take reset values before the next edge. After release, the next pix_en_i cycle gives (0,0) with frame_start_o = 1.
